// File: rtl/counter_pkg.sv
// counter_pkg: shared constants and the next-count helper for the
// parametrised up/down counter family.
//
// Contents:
//   CNT_DIR_UP / CNT_DIR_DN       encodings for the up_dn input
//   CNT_MODE_WRAP / CNT_MODE_SAT  encodings for the sat_mode input
//   cnt_step_t                    result of one step: next value + boundary flag
//   cnt_next()                    one-step next-value and boundary detection
//
// cnt_next works on CNT_W_MAX-bit operands so that one function serves
// every counter width; callers zero-extend their count on the way in and
// truncate the value on the way out (counters are limited to 32 bits).
package counter_pkg;

  localparam int CNT_W_MAX = 32;

  localparam logic CNT_DIR_UP    = 1'b1;
  localparam logic CNT_DIR_DN    = 1'b0;
  localparam logic CNT_MODE_WRAP = 1'b0;
  localparam logic CNT_MODE_SAT  = 1'b1;

  typedef struct packed {
    logic                 boundary;  // step hit MAX_VAL (up) or 0 (down)
    logic [CNT_W_MAX-1:0] value;     // count after the step
  } cnt_step_t;

  function automatic cnt_step_t cnt_next(
    input logic [CNT_W_MAX-1:0] count,
    input logic                 up_dn,
    input logic                 sat_mode,
    input logic [CNT_W_MAX-1:0] max_val
  );
    cnt_step_t r;
    r.boundary = 1'b0;
    r.value    = count;
    if (up_dn == CNT_DIR_UP) begin
      // >= rather than == keeps the result in range even for a count that
      // somehow sits above max_val.
      if (count >= max_val) begin
        r.boundary = 1'b1;
        r.value    = (sat_mode == CNT_MODE_SAT) ? max_val : '0;
      end else begin
        r.value = count + 1'b1;
      end
    end else begin
      if (count == '0) begin
        r.boundary = 1'b1;
        r.value    = (sat_mode == CNT_MODE_SAT) ? '0 : max_val;
      end else begin
        r.value = count - 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cnt_next_calc.sv
// cnt_next_calc: combinational next-value and boundary detection for one
// counting step of param_updown_counter.
//
// Parameters: WIDTH (count width, 2..32), MAX_VAL (highest count value).
// Ports:
//   count     in   WIDTH  current registered count
//   up_dn     in   1      1 = up, 0 = down
//   sat_mode  in   1      1 = saturate at boundary, 0 = wrap
//   next_val  out  WIDTH  count after one enabled step
//   boundary  out  1      this step is a boundary step (drives tc)
module cnt_next_calc
  import counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = 2**WIDTH - 1
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up_dn,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] next_val,
  output logic             boundary
);

  localparam logic [CNT_W_MAX-1:0] MAX_W = MAX_VAL;

  cnt_step_t step;

  assign step     = cnt_next(CNT_W_MAX'(count), up_dn, sat_mode, MAX_W);
  // Upper bits are always zero because value never exceeds MAX_VAL.
  assign next_val = WIDTH'(step.value);
  assign boundary = step.boundary;

endmodule

// File: rtl/param_updown_counter.sv
// param_updown_counter: parametrised up/down counter over 0..MAX_VAL with
// enable, synchronous parallel load (clamped to MAX_VAL), wrap or saturate
// mode and a registered terminal-count pulse. Instances cascade tc -> en.
//
// Parameters: WIDTH (2..32), MAX_VAL (1..2**WIDTH-1), RST_VAL (0..MAX_VAL).
// Ports:
//   clk         in   1      rising-edge clock
//   rst         in   1      synchronous reset, active-high, overrides all
//   en          in   1      count enable, one step per enabled cycle
//   up_dn       in   1      1 = up, 0 = down
//   sat_mode    in   1      1 = saturate, 0 = wrap
//   load        in   1      synchronous parallel load strobe (beats en)
//   load_val    in   WIDTH  value to load, clamped to MAX_VAL
//   count       out  WIDTH  registered count
//   tc          out  1      registered terminal-count pulse
//   at_max      out  1      count == MAX_VAL (combinational)
//   at_min      out  1      count == 0 (combinational)
//   ovf_clr     in   1      clear ovf_sticky (only with the macro below)
//   ovf_sticky  out  1      sticky boundary flag (only with the macro below)
//
// Optional feature macro: PARAM_UPDOWN_COUNTER_OVF_STICKY_EN adds the
// ovf_clr / ovf_sticky pair; without it those ports and the flag are absent.
//
// Edge priority: rst > load > en > hold.
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = 2**WIDTH - 1,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef PARAM_UPDOWN_COUNTER_OVF_STICKY_EN
  input  logic             ovf_clr,
  output logic             ovf_sticky,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_C = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] next_val;
  logic             boundary;
  logic [WIDTH-1:0] load_clamped;
  logic             tc_set;

  cnt_next_calc #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_next (
    .count    (count),
    .up_dn    (up_dn),
    .sat_mode (sat_mode),
    .next_val (next_val),
    .boundary (boundary)
  );

  // A load above MAX_VAL would put the counter out of range; pin it to MAX_VAL.
  assign load_clamped = (load_val > MAX_C) ? MAX_C : load_val;

  // tc is being set this edge: an enabled boundary step that load does not override.
  assign tc_set = !load && en && boundary;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= RST_C;
      tc    <= 1'b0;
    end else if (load) begin
      count <= load_clamped;
      tc    <= 1'b0;
    end else if (en) begin
      count <= next_val;
      tc    <= boundary;
    end else begin
      tc    <= 1'b0;
    end
  end

`ifdef PARAM_UPDOWN_COUNTER_OVF_STICKY_EN
  // Set beats clear so a boundary in the clearing cycle is not lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
    end else if (tc_set) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end
`else
  // Without the sticky flag tc_set has no consumer beyond documenting intent.
  logic tc_set_unused;
  assign tc_set_unused = tc_set;
`endif

  assign at_max = (count == MAX_C);
  assign at_min = (count == '0);

endmodule

// File: tb/tb_param_updown_counter.sv
// tb_param_updown_counter: directed bench for param_updown_counter.
// dut  : WIDTH=4, MAX_VAL=9, RST_VAL=0 (decade counter)
// dut4 : WIDTH=4, MAX_VAL=9, RST_VAL=4, sharing every input with dut
module tb_param_updown_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up_dn;
  logic       sat_mode;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] count, count4;
  logic       tc, tc4;
  logic       at_max, at_max4;
  logic       at_min, at_min4;
`ifdef PARAM_UPDOWN_COUNTER_OVF_STICKY_EN
  logic       ovf_clr;
  logic       ovf_sticky, ovf_sticky4;
`endif

  int checks;
  int failures;

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .RST_VAL(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .up_dn      (up_dn),
    .sat_mode   (sat_mode),
    .load       (load),
    .load_val   (load_val),
`ifdef PARAM_UPDOWN_COUNTER_OVF_STICKY_EN
    .ovf_clr    (ovf_clr),
    .ovf_sticky (ovf_sticky),
`endif
    .count      (count),
    .tc         (tc),
    .at_max     (at_max),
    .at_min     (at_min)
  );

  param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .RST_VAL(4)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .up_dn      (up_dn),
    .sat_mode   (sat_mode),
    .load       (load),
    .load_val   (load_val),
`ifdef PARAM_UPDOWN_COUNTER_OVF_STICKY_EN
    .ovf_clr    (ovf_clr),
    .ovf_sticky (ovf_sticky4),
`endif
    .count      (count4),
    .tc         (tc4),
    .at_max     (at_max4),
    .at_min     (at_min4)
  );

  // driver: advance one active edge, then sample 1 ns later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cnt(input string tag, input logic [3:0] c, input logic t);
    check({tag, ".count"}, 32'(count), 32'(c));
    check({tag, ".tc"}, 32'(tc), 32'(t));
  endtask

  initial begin
    logic [3:0] exp_c;
    logic [3:0] exp_c4;
    logic [3:0] dn_cnt [5];
    logic       dn_tc  [5];
    checks   = 0;
    failures = 0;
    rst = 1'b1; en = 1'b0; up_dn = 1'b1; sat_mode = 1'b0;
    load = 1'b0; load_val = 4'd0;
`ifdef PARAM_UPDOWN_COUNTER_OVF_STICKY_EN
    ovf_clr = 1'b0;
`endif

    // reset for two edges
    step(); step();
    check_cnt("reset", 4'd0, 1'b0);
    check("reset.at_min", 32'(at_min), 32'd1);
    check("reset.at_max", 32'(at_max), 32'd0);
    check("reset4.count", 32'(count4), 32'd4);
    check("reset4.tc", 32'(tc4), 32'd0);
`ifdef PARAM_UPDOWN_COUNTER_OVF_STICKY_EN
    check("reset.ovf_sticky", 32'(ovf_sticky), 32'd0);
`endif

    // up, wrap mode, 12 cycles: 1..9,0,1,2 (dut4: 5..9,0,1..6)
    rst = 1'b0; en = 1'b1; up_dn = 1'b1; sat_mode = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      exp_c  = 4'((i + 1) % 10);
      exp_c4 = 4'((i + 5) % 10);
      check_cnt("up_wrap", exp_c, exp_c == 4'd0);
      check("up_wrap.at_max", 32'(at_max), 32'(exp_c == 4'd9));
      check("up_wrap4.count", 32'(count4), 32'(exp_c4));
      check("up_wrap4.tc", 32'(tc4), 32'(exp_c4 == 4'd0));
    end

    // load 3, then count down in sat mode: 2,1,0,0,0
    load = 1'b1; load_val = 4'd3; en = 1'b0;
    step();
    check_cnt("load3", 4'd3, 1'b0);
    load = 1'b0; en = 1'b1; up_dn = 1'b0; sat_mode = 1'b1;
    dn_cnt = '{4'd2, 4'd1, 4'd0, 4'd0, 4'd0};
    dn_tc  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      step();
      check_cnt("dn_sat", dn_cnt[i], dn_tc[i]);
    end
    check("dn_sat.at_min", 32'(at_min), 32'd1);

    // load clamp: 13 -> 9
    load = 1'b1; load_val = 4'd13; en = 1'b0;
    step();
    check_cnt("clamp", 4'd9, 1'b0);
    check("clamp.at_max", 32'(at_max), 32'd1);

    // load and en together: load wins, no step
    load = 1'b1; load_val = 4'd5; en = 1'b1; up_dn = 1'b1;
    step();
    check_cnt("load_beats_en", 4'd5, 1'b0);

    // count up to 6 from 0, then reset mid-count with en still high
    load = 1'b1; load_val = 4'd0; en = 1'b0; sat_mode = 1'b0;
    step();
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check_cnt("pre_rst", 4'd6, 1'b0);
    rst = 1'b1;
    step();
    check_cnt("mid_rst", 4'd0, 1'b0);
    check("mid_rst4.count", 32'(count4), 32'd4);
    rst = 1'b0;
    step();
    check_cnt("resume", 4'd1, 1'b0);
    check("resume4.count", 32'(count4), 32'd5);

    // reach tc=1 then reset: the pending tc must clear
    load = 1'b1; load_val = 4'd9;
    step();
    load = 1'b0;
    step();
    check_cnt("wrap_before_rst", 4'd0, 1'b1);
    rst = 1'b1;
    step();
    check_cnt("rst_clears_tc", 4'd0, 1'b0);

    // toggle direction every cycle from 0 in wrap mode: 9,0,9,0
    rst = 1'b0; en = 1'b1; sat_mode = 1'b0;
    up_dn = 1'b0; step();
    check_cnt("toggle1", 4'd9, 1'b1);
    check("toggle1_4.count", 32'(count4), 32'd3);
    up_dn = 1'b1; step();
    check_cnt("toggle2", 4'd0, 1'b1);
    check("toggle2_4.count", 32'(count4), 32'd4);
    up_dn = 1'b0; step();
    check_cnt("toggle3", 4'd9, 1'b1);
    check("toggle3_4.tc", 32'(tc4), 32'd0);
    up_dn = 1'b1; step();
    check_cnt("toggle4", 4'd0, 1'b1);

    // hold: tc falls back to 0, count unchanged
    en = 1'b0; step();
    check_cnt("hold", 4'd0, 1'b0);

    // saturate up at MAX_VAL with en held: tc every cycle
    load = 1'b1; load_val = 4'd9;
    step();
    load = 1'b0; en = 1'b1; up_dn = 1'b1; sat_mode = 1'b1;
    step();
    check_cnt("up_sat1", 4'd9, 1'b1);
    step();
    check_cnt("up_sat2", 4'd9, 1'b1);

`ifdef PARAM_UPDOWN_COUNTER_OVF_STICKY_EN
    // sticky overflow flag
    rst = 1'b1; en = 1'b0; sat_mode = 1'b0;
    step();
    check("ovf.rst", 32'(ovf_sticky), 32'd0);
    rst = 1'b0; load = 1'b1; load_val = 4'd9;
    step();
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    step();
    check_cnt("ovf.wrap", 4'd0, 1'b1);
    check("ovf.set", 32'(ovf_sticky), 32'd1);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("ovf.hold", 32'(ovf_sticky), 32'd1);
    end
    ovf_clr = 1'b1;
    step();
    check("ovf.clr", 32'(ovf_sticky), 32'd0);
    ovf_clr = 1'b0; load = 1'b1; load_val = 4'd9;
    step();
    load = 1'b0; en = 1'b1; ovf_clr = 1'b1;
    step();
    check("ovf.set_beats_clr", 32'(ovf_sticky), 32'd1);
    ovf_clr = 1'b0; en = 1'b0;
    step();
    check("ovf.after", 32'(ovf_sticky), 32'd1);
`endif

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
